// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
//   UART transmitter clocked at the baud rate (one serial bit per clock).
//   Accepts a parallel word on a one-cycle strobe while idle and shifts out
//   start(0), data LSB-first, optional parity, stop(1). Both outputs are
//   registered and driven from the next-state decode, so the line changes
//   on the same edge that the FSM changes state.
//
//   Ports
//     CLK_TOP        in   transmit clock at baud rate (rising edge)
//     RST_TOP        in   synchronous, active-low reset
//     P_DATA_TOP     in   parallel word, latched on an accepted strobe
//     Data_Valid_TOP in   one-cycle load strobe, honoured only while idle
//     PAR_EN_TOP     in   1 = append a parity bit (latched on accept)
//     PAR_TYP_TOP    in   0 = even, 1 = odd parity (latched on accept)
//     TX_OUT_TOP     out  serial line, idles high
//     busy_TOP       out  high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx_top #(
  parameter int DATA_WIDTH_TOP = 8
) (
  input  logic                      CLK_TOP,
  input  logic                      RST_TOP,
  input  logic [DATA_WIDTH_TOP-1:0] P_DATA_TOP,
  input  logic                      Data_Valid_TOP,
  input  logic                      PAR_EN_TOP,
  input  logic                      PAR_TYP_TOP,
  output logic                      TX_OUT_TOP,
  output logic                      busy_TOP
);

  localparam int CNT_W = (DATA_WIDTH_TOP > 1) ? $clog2(DATA_WIDTH_TOP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH_TOP - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH_TOP-1:0] shift_reg, shift_nxt;
  logic [DATA_WIDTH_TOP-1:0] data_q;
  logic                      par_en_q, par_typ_q;
  logic                      accept;
  logic                      tx_nxt;

  // Parity over the latched word; odd parity is the inverted XOR-reduce.
  function automatic logic parity_bit(input logic [DATA_WIDTH_TOP-1:0] d,
                                      input logic                      odd);
    return (^d) ^ odd;
  endfunction

  // Next-state, serializer and output-mux decode. tx_nxt is the value the
  // line takes after the coming edge, i.e. the mux is driven by state_nxt.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    tx_nxt      = 1'b1;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid_TOP) begin
          accept    = 1'b1;
          state_nxt = START;
          shift_nxt = P_DATA_TOP;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        tx_nxt      = shift_reg[0];
      end
      DATA: begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt_nxt = '0;
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = parity_bit(data_q, par_typ_q);
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          // Bit 0 went out on entry to DATA; each further cycle presents
          // the next bit by shifting it down into position 0.
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          shift_nxt   = shift_reg >> 1;
          tx_nxt      = shift_nxt[0];
        end
      end
      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end
      STOP: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // State, serializer and registered outputs.
  always_ff @(posedge CLK_TOP) begin
    if (!RST_TOP) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      TX_OUT_TOP <= 1'b1;
      busy_TOP   <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      TX_OUT_TOP <= tx_nxt;
      busy_TOP   <= (state_nxt != IDLE);
      if (accept) begin
        data_q    <= P_DATA_TOP;
        par_en_q  <= PAR_EN_TOP;
        par_typ_q <= PAR_TYP_TOP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_top
//   Directed bench for uart_tx_top (8-bit data). Each strobe pushes the
//   expected line sequence onto a queue; the line is then compared bit by
//   bit as the frame emerges. Inputs change and outputs are sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       valid;
  logic       par_en;
  logic       par_typ;
  logic       tx;
  logic       busy;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_top #(.DATA_WIDTH_TOP(8)) dut (
    .CLK_TOP       (clk),
    .RST_TOP       (rst),
    .P_DATA_TOP    (p_data),
    .Data_Valid_TOP(valid),
    .PAR_EN_TOP    (par_en),
    .PAR_TYP_TOP   (par_typ),
    .TX_OUT_TOP    (tx),
    .busy_TOP      (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Strobe one word; exp_par is the parity bit the frame must carry.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                      input logic exp_par);
    p_data  = d;
    par_en  = pen;
    par_typ = ptyp;
    valid   = 1'b1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back(exp_par);
    exp_q.push_back(1'b1);
    tick();
    valid = 1'b0;
  endtask

  task automatic check_bit(input string tag);
    logic e;
    e = exp_q.pop_front();
    chk({tag, "_tx"}, tx, e);
    chk({tag, "_busy"}, busy, 1'b1);
    tick();
  endtask

  // Remaining frame bits, then the line must be idle with busy low.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) check_bit(tag);
    chk({tag, "_end_tx"}, tx, 1'b1);
    chk({tag, "_end_busy"}, busy, 1'b0);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_tx"}, tx, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
    end
  endtask

  initial begin
    rst     = 1'b0;
    valid   = 1'b0;
    p_data  = 8'h00;
    par_en  = 1'b0;
    par_typ = 1'b0;

    // Reset held 3 cycles, with a strobe that must be ignored.
    tick();
    chk("rst0_tx", tx, 1'b1);
    chk("rst0_busy", busy, 1'b0);
    p_data = 8'h99;
    valid  = 1'b1;
    idle_check("rst1", 1);
    valid = 1'b0;
    idle_check("rst2", 1);
    rst = 1'b1;
    idle_check("post_rst", 4);

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    drain("a5_np");
    idle_check("gap1", 2);

    send(8'hA5, 1'b1, 1'b0, 1'b0);
    drain("a5_even");
    idle_check("gap2", 2);

    send(8'h01, 1'b1, 1'b0, 1'b1);
    drain("01_even");
    idle_check("gap3", 2);

    send(8'h01, 1'b1, 1'b1, 1'b0);
    drain("01_odd");
    idle_check("gap4", 2);

    // Strobe while busy plus mid-frame PAR_EN flip must not disturb 0x3C.
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) check_bit("ign");
    p_data = 8'hFF;
    par_en = 1'b1;
    valid  = 1'b1;
    check_bit("ign");
    valid  = 1'b0;
    p_data = 8'h00;
    drain("ign");
    par_en = 1'b0;
    idle_check("no_second", 14);

    // Back-to-back: second strobe on the first cycle busy is low.
    send(8'h55, 1'b0, 1'b0, 1'b0);
    drain("b2b_55");
    send(8'hAA, 1'b0, 1'b0, 1'b0);
    drain("b2b_aa");
    idle_check("gap5", 2);

    // Mid-frame reset during data bit 4 of 0x0F.
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) check_bit("abort");
    chk("abort_b4_tx", tx, exp_q.pop_front());
    rst    = 1'b0;
    valid  = 1'b1;
    p_data = 8'hC3;
    tick();
    valid = 1'b0;
    chk("abort_rst_tx", tx, 1'b1);
    chk("abort_rst_busy", busy, 1'b0);
    exp_q.delete();
    rst = 1'b1;
    idle_check("abort_idle", 2);

    send(8'h81, 1'b0, 1'b0, 1'b0);
    drain("after_abort_81");
    idle_check("final", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
